// File: rtl/uart_chip_responder.sv
// Board-edge stand-in for the parallel-strobe UART chip: strobe interface plus 8N1 serial TX/RX.
// Optional even parity (8E1 frames) is built when UART_PARITY_EN is defined.
module uart_chip_responder #(
   parameter int unsigned CLK_FREQ = 11059200,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rdn,
   input  logic       uart_wrn,
   input  logic [7:0] uart_wdata,
   output logic [7:0] uart_rdata,
   output logic       uart_rdata_oe,
   output logic       uart_dataready,
   output logic       uart_tbre,
   output logic       uart_tsre,
   input  logic       rxd,
   output logic       txd
);

   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned CW  = $clog2(DIV);
   localparam logic [CW-1:0] BitLast  = CW'(DIV - 1);
   localparam logic [CW-1:0] HalfLast = CW'(DIV / 2 - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   logic [2:0]    rdn_sync_q, rdn_sync_d, wrn_sync_q, wrn_sync_d;
   logic [1:0]    rxd_sync_q, rxd_sync_d;
   logic          rd_evt, wr_evt, rxd_s;

   state_e        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic [7:0]    hold_q, hold_d, rdata_q, rdata_d;
   logic          tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d, dr_q, dr_d;
   logic          tx_tick, rx_tick, tx_load, rx_good;
`ifdef UART_PARITY_EN
   logic          tx_par_q, tx_par_d, rx_par_ok_q, rx_par_ok_d;
`endif

   // Bit [2] of each strobe synchronizer is the previous synced value, used for edge detection.
   always_comb begin
      rdn_sync_d = {rdn_sync_q[1:0], uart_rdn};
      wrn_sync_d = {wrn_sync_q[1:0], uart_wrn};
      rxd_sync_d = {rxd_sync_q[0], rxd};
   end

   assign rd_evt  = rdn_sync_q[1] & ~rdn_sync_q[2];
   assign wr_evt  = ~wrn_sync_q[1] & wrn_sync_q[2];
   assign rxd_s   = rxd_sync_q[1];
   assign tx_tick = (tx_cnt_q == BitLast);
   assign rx_tick = (rx_cnt_q == BitLast);

   always_comb begin : tx_next
      tx_state_d = tx_state_q;
      tx_cnt_d   = (tx_state_q == StIdle || tx_tick) ? '0 : tx_cnt_q + 1'b1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      hold_d     = hold_q;
      tbre_d     = tbre_q;
      tsre_d     = tsre_q;
      txd_d      = txd_q;
      tx_load    = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      if (wr_evt && tbre_q) begin
         hold_d = uart_wdata;
         tbre_d = 1'b0;
      end
      unique case (tx_state_q)
         StIdle: begin
            txd_d   = 1'b1;
            tx_load = ~tbre_q;
         end
         StStart: if (tx_tick) begin
            tx_state_d = StData;
            txd_d      = tx_shift_q[0];
         end
         StData: if (tx_tick) begin
            if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
               tx_state_d = StParity;
               txd_d      = tx_par_q;
`else
               tx_state_d = StStop;
               txd_d      = 1'b1;
`endif
            end else begin
               tx_bit_d   = tx_bit_q + 3'd1;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               txd_d      = tx_shift_q[1];
            end
         end
`ifdef UART_PARITY_EN
         StParity: if (tx_tick) begin
            tx_state_d = StStop;
            txd_d      = 1'b1;
         end
`endif
         StStop: if (tx_tick) begin
            // A waiting byte starts its frame with no idle gap.
            if (!tbre_q) begin
               tx_load = 1'b1;
            end else begin
               tx_state_d = StIdle;
               tsre_d     = 1'b1;
               txd_d      = 1'b1;
            end
         end
         default: tx_state_d = StIdle;
      endcase
      if (tx_load) begin
         tx_shift_d = hold_q;
         tbre_d     = 1'b1;
         tsre_d     = 1'b0;
         tx_state_d = StStart;
         tx_cnt_d   = '0;
         tx_bit_d   = '0;
         txd_d      = 1'b0;
`ifdef UART_PARITY_EN
         tx_par_d   = ^hold_q;
`endif
      end
   end

   always_comb begin : rx_next
      rx_state_d = rx_state_q;
      rx_cnt_d   = (rx_state_q == StIdle || rx_tick) ? '0 : rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_good    = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_ok_d = rx_par_ok_q;
`endif
      unique case (rx_state_q)
         StIdle: if (!rxd_s) rx_state_d = StStart;
         StStart: if (rx_cnt_q == HalfLast) begin
            // Mid start bit: a line already back high was a glitch.
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rxd_s ? StIdle : StData;
         end
         StData: if (rx_tick) begin
            rx_shift_d = {rxd_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
               rx_state_d = StParity;
`else
               rx_state_d = StStop;
`endif
            end else begin
               rx_bit_d = rx_bit_q + 3'd1;
            end
         end
`ifdef UART_PARITY_EN
         StParity: if (rx_tick) begin
            rx_par_ok_d = (rxd_s == ^rx_shift_q);
            rx_state_d  = StStop;
         end
`endif
         StStop: if (rx_tick) begin
            rx_state_d = StIdle;
`ifdef UART_PARITY_EN
            rx_good    = rxd_s & rx_par_ok_q;
`else
            rx_good    = rxd_s;
`endif
         end
         default: rx_state_d = StIdle;
      endcase
      // The read clear is applied before the new byte is considered.
      dr_d    = dr_q & ~rd_evt;
      rdata_d = rdata_q;
      if (rx_good && !dr_d) begin
         rdata_d = rx_shift_q;
         dr_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdn_sync_q  <= '1;
         wrn_sync_q  <= '1;
         rxd_sync_q  <= '1;
         tx_state_q  <= StIdle;
         rx_state_q  <= StIdle;
         tx_cnt_q    <= '0;
         rx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         rx_bit_q    <= '0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         hold_q      <= '0;
         rdata_q     <= '0;
         tbre_q      <= 1'b1;
         tsre_q      <= 1'b1;
         txd_q       <= 1'b1;
         dr_q        <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par_q    <= 1'b0;
         rx_par_ok_q <= 1'b0;
`endif
      end else begin
         rdn_sync_q  <= rdn_sync_d;
         wrn_sync_q  <= wrn_sync_d;
         rxd_sync_q  <= rxd_sync_d;
         tx_state_q  <= tx_state_d;
         rx_state_q  <= rx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         rx_bit_q    <= rx_bit_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         hold_q      <= hold_d;
         rdata_q     <= rdata_d;
         tbre_q      <= tbre_d;
         tsre_q      <= tsre_d;
         txd_q       <= txd_d;
         dr_q        <= dr_d;
`ifdef UART_PARITY_EN
         tx_par_q    <= tx_par_d;
         rx_par_ok_q <= rx_par_ok_d;
`endif
      end
   end

   assign uart_rdata     = rdata_q;
   assign uart_rdata_oe  = ~uart_rdn;
   assign uart_dataready = dr_q;
   assign uart_tbre      = tbre_q;
   assign uart_tsre      = tsre_q;
   assign txd            = txd_q;

endmodule

// File: tb/tb_uart_chip_responder.sv
// Directed bench for uart_chip_responder at DIV=16; define UART_PARITY_EN to cover 8E1 frames.
module tb_uart_chip_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rdn = 1'b1;
   logic       uart_wrn = 1'b1;
   logic [7:0] uart_wdata = 8'h00;
   logic [7:0] uart_rdata;
   logic       uart_rdata_oe;
   logic       uart_dataready;
   logic       uart_tbre;
   logic       uart_tsre;
   logic       rxd = 1'b1;
   logic       txd;

   int vectors = 0;
   int miscompares = 0;

   uart_chip_responder #(
      .CLK_FREQ(16),
      .BAUD    (1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .uart_rdn      (uart_rdn),
      .uart_wrn      (uart_wrn),
      .uart_wdata    (uart_wdata),
      .uart_rdata    (uart_rdata),
      .uart_rdata_oe (uart_rdata_oe),
      .uart_dataready(uart_dataready),
      .uart_tbre     (uart_tbre),
      .uart_tsre     (uart_tsre),
      .rxd           (rxd),
      .txd           (txd)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Entered c cycles after the start bit first shows on txd; returns at mid stop bit.
   task automatic tx_frame(input logic [7:0] exp, input int c);
      cyc(8 - c);
      chk1($sformatf("tx%h_start", exp), txd, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(16);
         chk1($sformatf("tx%h_bit%0d", exp, i), txd, exp[i]);
      end
`ifdef UART_PARITY_EN
      cyc(16);
      chk1($sformatf("tx%h_par", exp), txd, ^exp);
`endif
      cyc(16);
      chk1($sformatf("tx%h_stop", exp), txd, 1'b1);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      rxd = 1'b0;
      cyc(16);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         cyc(16);
      end
`ifdef UART_PARITY_EN
      rxd = (^b) ^ par_flip;
      cyc(16);
`else
      rxd = par_flip & 1'b0;
`endif
      rxd = stop_bit;
      cyc(16);
      rxd = 1'b1;
   endtask

   task automatic read_strobe;
      uart_rdn = 1'b0;
      cyc(1);
      chk1("rd_oe_low", uart_rdata_oe, 1'b1);
      cyc(2);
      chk1("rd_dr_held", uart_dataready, 1'b1);
      uart_rdn = 1'b1;
      cyc(1);
      chk1("rd_oe_high", uart_rdata_oe, 1'b0);
      cyc(3);
      chk1("rd_dr_clear", uart_dataready, 1'b0);
   endtask

   initial begin
      cyc(3);
      chk8("rst_rdata", uart_rdata, 8'h00);
      chk1("rst_dr", uart_dataready, 1'b0);
      chk1("rst_tbre", uart_tbre, 1'b1);
      chk1("rst_tsre", uart_tsre, 1'b1);
      chk1("rst_txd", txd, 1'b1);
      chk1("rst_oe", uart_rdata_oe, 1'b0);
      rst_n = 1'b1;
      cyc(4);

      // Single write: latency and frame shape.
      uart_wdata = 8'h55;
      uart_wrn   = 1'b0;
      cyc(2);
      chk1("w55_tbre_n2", uart_tbre, 1'b1);
      cyc(1);
      chk1("w55_tbre_n3", uart_tbre, 1'b0);
      chk1("w55_txd_n3", txd, 1'b1);
      cyc(1);
      chk1("w55_txd_n4", txd, 1'b0);
      chk1("w55_tbre_n4", uart_tbre, 1'b1);
      chk1("w55_tsre_n4", uart_tsre, 1'b0);
      uart_wrn = 1'b1;
      tx_frame(8'h55, 0);
      cyc(7);
      chk1("w55_tsre_busy", uart_tsre, 1'b0);
      cyc(1);
      chk1("w55_tsre_done", uart_tsre, 1'b1);
      chk1("w55_txd_idle", txd, 1'b1);
      cyc(10);

      // Back-to-back frames with a dropped third write.
      uart_wdata = 8'hA5;
      uart_wrn   = 1'b0;
      cyc(4);
      chk1("b2b_start1", txd, 1'b0);
      uart_wrn = 1'b1;
      cyc(3);
      uart_wdata = 8'h3C;
      uart_wrn   = 1'b0;
      cyc(3);
      chk1("b2b_tbre_full", uart_tbre, 1'b0);
      uart_wrn = 1'b1;
      tx_frame(8'hA5, 6);
      uart_wdata = 8'hFF;
      uart_wrn   = 1'b0;
      cyc(8);
      chk1("b2b_start2", txd, 1'b0);
      chk1("b2b_tbre2", uart_tbre, 1'b1);
      chk1("b2b_tsre2", uart_tsre, 1'b0);
      tx_frame(8'h3C, 0);
      cyc(8);
      chk1("b2b_tsre_done", uart_tsre, 1'b1);
      uart_wrn = 1'b1;
      cyc(40);
      chk1("drop_txd_idle", txd, 1'b1);
      chk1("drop_tsre", uart_tsre, 1'b1);
      chk1("drop_tbre", uart_tbre, 1'b1);

      // Receive path.
      send_rx(8'hC3, 1'b1, 1'b0);
      cyc(4);
      chk1("rxC3_dr", uart_dataready, 1'b1);
      chk8("rxC3_data", uart_rdata, 8'hC3);
      send_rx(8'h11, 1'b1, 1'b0);
      cyc(4);
      chk1("ovr_dr", uart_dataready, 1'b1);
      chk8("ovr_data", uart_rdata, 8'hC3);
      read_strobe();
      chk8("rd_data_kept", uart_rdata, 8'hC3);
      rxd = 1'b0;
      cyc(4);
      rxd = 1'b1;
      cyc(40);
      chk1("glitch_dr", uart_dataready, 1'b0);
      send_rx(8'h5A, 1'b0, 1'b0);
      cyc(40);
      chk1("frm_dr", uart_dataready, 1'b0);
      chk8("frm_data", uart_rdata, 8'hC3);
      send_rx(8'h96, 1'b1, 1'b0);
      cyc(4);
      chk1("rx96_dr", uart_dataready, 1'b1);
      chk8("rx96_data", uart_rdata, 8'h96);

`ifdef UART_PARITY_EN
      read_strobe();
      send_rx(8'h5A, 1'b1, 1'b1);
      cyc(20);
      chk1("par_bad_dr", uart_dataready, 1'b0);
      send_rx(8'h5A, 1'b1, 1'b0);
      cyc(4);
      chk1("par_good_dr", uart_dataready, 1'b1);
      chk8("par_good_data", uart_rdata, 8'h5A);
      uart_wdata = 8'h07;
      uart_wrn   = 1'b0;
      cyc(4);
      chk1("par07_start", txd, 1'b0);
      uart_wrn = 1'b1;
      tx_frame(8'h07, 0);
      cyc(20);
`endif

      // Reset in the middle of a TX frame, with a byte pending in RX.
      uart_wdata = 8'h0F;
      uart_wrn   = 1'b0;
      cyc(4);
      chk1("mid_start", txd, 1'b0);
      uart_wrn = 1'b1;
      cyc(19);
      chk1("mid_bit0", txd, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_txd", txd, 1'b1);
      chk1("mid_rst_tbre", uart_tbre, 1'b1);
      chk1("mid_rst_tsre", uart_tsre, 1'b1);
      chk1("mid_rst_dr", uart_dataready, 1'b0);
      chk8("mid_rst_data", uart_rdata, 8'h00);
      cyc(2);
      rst_n = 1'b1;
      cyc(40);
      chk1("post_rst_txd", txd, 1'b1);
      chk1("post_rst_tsre", uart_tsre, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
